// File: rtl/ama_riscv_fwd_hazard_unit_pkg.sv
// Shared constants and helpers for the forwarding / load-use hazard unit.
// Stage indices name the tracker slots; 0 always means "no forward".
package ama_riscv_fwd_hazard_unit_pkg;

  localparam int FWD_SEL_NONE  = 0;
  localparam int FWD_STAGE_EX  = 1;
  localparam int FWD_STAGE_MEM = 2;
  localparam int FWD_STAGE_WB  = 3;
  localparam int RF_X0_ZERO    = 0;

  // Operand slots served by the unit, in output order.
  typedef enum logic [1:0] {
    OPR_ALU_A  = 2'd0,
    OPR_ALU_B  = 2'd1,
    OPR_BC_A   = 2'd2,
    OPR_BCS_B  = 2'd3
  } fwd_opr_e;

  localparam int NUM_OPR = 4;

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/ama_riscv_fwd_hazard_unit_if.sv
// ID-stage view of the hazard unit: instruction fields in, forward selects and stall out.
// master = ID/decode side, slave = hazard unit.
interface ama_riscv_fwd_hazard_unit_if #(
  parameter int RF_ADDR_W = 5,
  parameter int SEL_W     = 2
);

  logic                 id_valid;
  logic [RF_ADDR_W-1:0] rs1_id;
  logic [RF_ADDR_W-1:0] rs2_id;
  logic [RF_ADDR_W-1:0] rd_id;
  logic                 reg_we_id;
  logic                 load_inst_id;
  logic                 alu_a_sel;
  logic                 alu_b_sel;
  logic                 store_inst_id;
  logic                 branch_inst_id;
  logic                 stall_ext;
  logic                 flush_ex;

  logic [SEL_W-1:0]     alu_a_sel_fwd;
  logic [SEL_W-1:0]     alu_b_sel_fwd;
  logic [SEL_W-1:0]     bc_a_sel_fwd;
  logic [SEL_W-1:0]     bcs_b_sel_fwd;
  logic                 stall_id;

  modport master (
    output id_valid, rs1_id, rs2_id, rd_id, reg_we_id, load_inst_id,
           alu_a_sel, alu_b_sel, store_inst_id, branch_inst_id,
           stall_ext, flush_ex,
    input  alu_a_sel_fwd, alu_b_sel_fwd, bc_a_sel_fwd, bcs_b_sel_fwd, stall_id
  );

  modport slave (
    input  id_valid, rs1_id, rs2_id, rd_id, reg_we_id, load_inst_id,
           alu_a_sel, alu_b_sel, store_inst_id, branch_inst_id,
           stall_ext, flush_ex,
    output alu_a_sel_fwd, alu_b_sel_fwd, bc_a_sel_fwd, bcs_b_sel_fwd, stall_id
  );

endinterface

// File: rtl/ama_riscv_fwd_prio_enc.sv
// Priority encoder: bit i of match is stage i+1; returns the youngest (lowest) stage
// index that matches, or 0 when nothing matches, plus a found flag.
module ama_riscv_fwd_prio_enc
  import ama_riscv_fwd_hazard_unit_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int SEL_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic [NUM_STAGES-1:0] match,
  output logic [SEL_W-1:0]      idx,
  output logic                  found
);

  // Scan oldest to youngest so the youngest hit is the last assignment.
  always_comb begin
    idx = SEL_W'(FWD_SEL_NONE);
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (match[i]) begin
        idx = SEL_W'(i + 1);
      end
    end
  end

  assign found = |match;

endmodule

// File: rtl/ama_riscv_fwd_hazard_unit.sv
// Operand forwarding select and load-use stall generation for NUM_STAGES post-ID stages.
// Optional perf counters (fwd_cnt, stall_cnt) when AMA_RISCV_FWD_PERF_CNT_EN is defined.
module ama_riscv_fwd_hazard_unit
  import ama_riscv_fwd_hazard_unit_pkg::*;
#(
  parameter int NUM_STAGES = 3,   // legal 1..7
  parameter int RF_ADDR_W  = 5,
  parameter int LOAD_LAT   = 1,   // must be < NUM_STAGES
  parameter int SEL_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  ama_riscv_fwd_hazard_unit_if.slave bus
`ifdef AMA_RISCV_FWD_PERF_CNT_EN
  ,
  output logic [31:0]               fwd_cnt,
  output logic [31:0]               stall_cnt
`endif
);

  localparam int EX_IDX = FWD_STAGE_EX - 1;

  // Tracker: bit i / element i describes the instruction in stage i+1.
  logic [NUM_STAGES-1:0] vld_reg, vld_next;
  logic [NUM_STAGES-1:0] we_reg,  we_next;
  logic [NUM_STAGES-1:0] ld_reg,  ld_next;
  logic [RF_ADDR_W-1:0]  rd_reg  [NUM_STAGES];
  logic [RF_ADDR_W-1:0]  rd_next [NUM_STAGES];

  logic                  stall_int;

  always_comb begin
    vld_next = vld_reg;
    we_next  = we_reg;
    ld_next  = ld_reg;
    rd_next  = rd_reg;
    if (!bus.stall_ext) begin
      for (int k = NUM_STAGES - 1; k >= 1; k--) begin
        vld_next[k] = vld_reg[k-1];
        we_next[k]  = we_reg[k-1];
        ld_next[k]  = ld_reg[k-1];
        rd_next[k]  = rd_reg[k-1];
      end
      // A stalled or squashed ID instruction must not appear as a producer in EX.
      if (stall_int || bus.flush_ex) begin
        vld_next[EX_IDX] = 1'b0;
        we_next[EX_IDX]  = 1'b0;
        ld_next[EX_IDX]  = 1'b0;
        rd_next[EX_IDX]  = '0;
      end else begin
        vld_next[EX_IDX] = bus.id_valid;
        we_next[EX_IDX]  = bus.reg_we_id;
        ld_next[EX_IDX]  = bus.load_inst_id;
        rd_next[EX_IDX]  = bus.rd_id;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_reg <= '0;
      we_reg  <= '0;
      ld_reg  <= '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
        rd_reg[k] <= '0;
      end
    end else begin
      vld_reg <= vld_next;
      we_reg  <= we_next;
      ld_reg  <= ld_next;
      rd_reg  <= rd_next;
    end
  end

  // Raw per-stage matches for each source register.
  logic [NUM_STAGES-1:0] rs1_match;
  logic [NUM_STAGES-1:0] rs2_match;

  generate
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_match
      assign rs1_match[gi] = vld_reg[gi] & we_reg[gi] &
                             (bus.rs1_id != RF_ADDR_W'(RF_X0_ZERO)) &
                             (rd_reg[gi] == bus.rs1_id);
      assign rs2_match[gi] = vld_reg[gi] & we_reg[gi] &
                             (bus.rs2_id != RF_ADDR_W'(RF_X0_ZERO)) &
                             (rd_reg[gi] == bus.rs2_id);
    end
  endgenerate

  logic                  opr_use   [NUM_OPR];
  logic [NUM_STAGES-1:0] opr_match [NUM_OPR];
  logic [SEL_W-1:0]      opr_idx   [NUM_OPR];
  logic                  opr_found [NUM_OPR];
  logic [SEL_W-1:0]      opr_sel   [NUM_OPR];

  assign opr_use[OPR_ALU_A] = !bus.alu_a_sel;
  assign opr_use[OPR_ALU_B] = !bus.alu_b_sel;
  assign opr_use[OPR_BC_A]  = bus.branch_inst_id;
  assign opr_use[OPR_BCS_B] = bus.store_inst_id | bus.branch_inst_id;

  assign opr_match[OPR_ALU_A] = rs1_match;
  assign opr_match[OPR_ALU_B] = rs2_match;
  assign opr_match[OPR_BC_A]  = rs1_match;
  assign opr_match[OPR_BCS_B] = rs2_match;

  // Selects are meaningless while resetting or when ID holds no instruction.
  logic sel_en;
  assign sel_en = !rst && bus.id_valid;

  generate
    for (genvar gi = 0; gi < NUM_OPR; gi++) begin : g_opr
      ama_riscv_fwd_prio_enc #(
        .NUM_STAGES (NUM_STAGES),
        .SEL_W      (SEL_W)
      ) u_enc (
        .match (opr_match[gi] & {NUM_STAGES{opr_use[gi]}}),
        .idx   (opr_idx[gi]),
        .found (opr_found[gi])
      );
      assign opr_sel[gi] = (sel_en && opr_found[gi]) ? opr_idx[gi] : SEL_W'(FWD_SEL_NONE);
    end
  endgenerate

  assign bus.alu_a_sel_fwd = opr_sel[OPR_ALU_A];
  assign bus.alu_b_sel_fwd = opr_sel[OPR_ALU_B];
  assign bus.bc_a_sel_fwd  = opr_sel[OPR_BC_A];
  assign bus.bcs_b_sel_fwd = opr_sel[OPR_BCS_B];

  // Stall only if the youngest producer is a load whose data is not ready yet;
  // a younger non-load producer shadows any older load.
  function automatic logic youngest_is_early_load(
    input logic [NUM_STAGES-1:0] match,
    input logic [NUM_STAGES-1:0] ld
  );
    logic hit;
    hit = 1'b0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit = (i < LOAD_LAT) && ld[i];
      end
    end
    return hit;
  endfunction

  logic rs1_used, rs2_used;
  logic rs1_hazard, rs2_hazard;

  assign rs1_used   = opr_use[OPR_ALU_A] | opr_use[OPR_BC_A];
  assign rs2_used   = opr_use[OPR_ALU_B] | opr_use[OPR_BCS_B];
  assign rs1_hazard = rs1_used && youngest_is_early_load(rs1_match, ld_reg);
  assign rs2_hazard = rs2_used && youngest_is_early_load(rs2_match, ld_reg);

  assign stall_int    = sel_en && (rs1_hazard || rs2_hazard);
  assign bus.stall_id = stall_int;

`ifdef AMA_RISCV_FWD_PERF_CNT_EN
  logic [31:0] fwd_cnt_reg;
  logic [31:0] stall_cnt_reg;
  logic        any_fwd;

  assign any_fwd = (opr_sel[OPR_ALU_A] != SEL_W'(FWD_SEL_NONE)) ||
                   (opr_sel[OPR_ALU_B] != SEL_W'(FWD_SEL_NONE)) ||
                   (opr_sel[OPR_BC_A]  != SEL_W'(FWD_SEL_NONE)) ||
                   (opr_sel[OPR_BCS_B] != SEL_W'(FWD_SEL_NONE));

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_cnt_reg   <= '0;
      stall_cnt_reg <= '0;
    end else begin
      if (any_fwd && !stall_int && !bus.stall_ext) begin
        fwd_cnt_reg <= sat_inc(fwd_cnt_reg);
      end
      if (stall_int) begin
        stall_cnt_reg <= sat_inc(stall_cnt_reg);
      end
    end
  end

  assign fwd_cnt   = fwd_cnt_reg;
  assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_ama_riscv_fwd_hazard_unit.sv
// Directed bench for ama_riscv_fwd_hazard_unit (NUM_STAGES=3, LOAD_LAT=1).
// Observed vector packs {alu_a, alu_b, bc_a, bcs_b, stall}.
module tb_ama_riscv_fwd_hazard_unit;
  import ama_riscv_fwd_hazard_unit_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;
  logic [8:0] got;
  logic [8:0] exp_v;

  ama_riscv_fwd_hazard_unit_if #(.RF_ADDR_W(5), .SEL_W(2)) bus ();

`ifdef AMA_RISCV_FWD_PERF_CNT_EN
  logic [31:0] fwd_cnt;
  logic [31:0] stall_cnt;
`endif

  ama_riscv_fwd_hazard_unit #(
    .NUM_STAGES (3),
    .RF_ADDR_W  (5),
    .LOAD_LAT   (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus)
`ifdef AMA_RISCV_FWD_PERF_CNT_EN
    ,
    .fwd_cnt   (fwd_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] outs();
    return {bus.alu_a_sel_fwd, bus.alu_b_sel_fwd, bus.bc_a_sel_fwd,
            bus.bcs_b_sel_fwd, bus.stall_id};
  endfunction

  function automatic logic [8:0] pack(input int a, input int b, input int c,
                                      input int d, input int s);
    return {2'(a), 2'(b), 2'(c), 2'(d), 1'(s)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic we, input logic ld,
                        input logic asel, input logic bsel, input logic st,
                        input logic br);
    bus.id_valid       = v;
    bus.rs1_id         = rs1;
    bus.rs2_id         = rs2;
    bus.rd_id          = rd;
    bus.reg_we_id      = we;
    bus.load_inst_id   = ld;
    bus.alu_a_sel      = asel;
    bus.alu_b_sel      = bsel;
    bus.store_inst_id  = st;
    bus.branch_inst_id = br;
    #1;
  endtask

  task automatic drain();
    bus.stall_ext = 1'b0;
    bus.flush_ex  = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic issue_alu(input logic [4:0] rd);
    set_id(1, 0, 0, rd, 1, 0, 0, 1, 0, 0);
    tick();
  endtask

  task automatic issue_load(input logic [4:0] rd);
    set_id(1, 0, 0, rd, 1, 1, 0, 1, 0, 0);
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.stall_ext = 1'b0;
    bus.flush_ex  = 1'b0;
    set_id(1, 5, 5, 5, 1, 1, 0, 0, 1, 1);
    tick();
    tick();
    got = outs(); exp_v = pack(0, 0, 0, 0, 0); n_cmp++;
    $display("chk in_reset got=%b exp=%b", got, exp_v);
    if (got !== exp_v) begin n_fail++; $display("FAIL in_reset got=%b exp=%b", got, exp_v); end
    rst = 1'b0;
    #1;
    got = outs(); exp_v = pack(0, 0, 0, 0, 0); n_cmp++;
    $display("chk after_reset got=%b exp=%b", got, exp_v);
    if (got !== exp_v) begin n_fail++; $display("FAIL after_reset got=%b exp=%b", got, exp_v); end
  endtask

  task automatic test_basic();
    drain();
    issue_alu(5);
    set_id(1, 5, 6, 8, 1, 0, 0, 0, 0, 0);
    got = outs(); exp_v = pack(FWD_STAGE_EX, 0, 0, 0, 0); n_cmp++;
    $display("chk alu_a_ex got=%b exp=%b", got, exp_v);
    if (got !== exp_v) begin n_fail++; $display("FAIL alu_a_ex got=%b exp=%b", got, exp_v); end
    set_id(0, 5, 6, 8, 1, 0, 0, 0, 0, 0);
    got = outs(); exp_v = pack(0, 0, 0, 0, 0); n_cmp++;
    $display("chk mask_invalid got=%b exp=%b", got, exp_v);
    if (got !== exp_v) begin n_fail++; $display("FAIL mask_invalid got=%b exp=%b", got, exp_v); end
    set_id(1, 5, 6, 8, 1, 0, 0, 0, 0, 0);
    tick();
    set_id(1, 0, 5, 0, 0, 0, 0, 0, 0, 0);
    got = outs(); exp_v = pack(0, FWD_STAGE_MEM, 0, 0, 0); n_cmp++;
    $display("chk alu_b_mem got=%b exp=%b", got, exp_v);
    if (got !== exp_v) begin n_fail++; $display("FAIL alu_b_mem got=%b exp=%b", got, exp_v); end
    tick();
    set_id(1, 5, 5, 0, 0, 0, 0, 1, 1, 0);
    got = outs(); exp_v = pack(FWD_STAGE_WB, 0, 0, FWD_STAGE_WB, 0); n_cmp++;
    $display("chk wb_store got=%b exp=%b", got, exp_v);
    if (got !== exp_v) begin n_fail++; $display("FAIL wb_store got=%b exp=%b", got, exp_v); end
    tick();
    got = outs(); exp_v = pack(0, 0, 0, 0, 0); n_cmp++;
    $display("chk aged_out got=%b exp=%b", got, exp_v);
    if (got !== exp_v) begin n_fail++; $display("FAIL aged_out got=%b exp=%b", got, exp_v); end
  endtask

  task automatic test_youngest();
    drain();
    issue_alu(5);
    issue_alu(5);
    set_id(1, 5, 0, 0, 0, 0, 0, 1, 0, 0);
    got = outs(); exp_v = pack(1, 0, 0, 0, 0); n_cmp++;
    $display("chk youngest got=%b exp=%b", got, exp_v);
    if (got !== exp_v) begin n_fail++; $display("FAIL youngest got=%b exp=%b", got, exp_v); end
    set_id(1, 5, 5, 0, 0, 0, 1, 1, 0, 1);
    got = outs(); exp_v = pack(0, 0, 1, 1, 0); n_cmp++;
    $display("chk branch_ex got=%b exp=%b", got, exp_v);
    if (got !== exp_v) begin n_fail++; $display("FAIL branch_ex got=%b exp=%b", got, exp_v); end
    issue_alu(0);
    set_id(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    got = outs(); exp_v = pack(0, 0, 0, 0, 0); n_cmp++;
    $display("chk x0_none got=%b exp=%b", got, exp_v);
    if (got !== exp_v) begin n_fail++; $display("FAIL x0_none got=%b exp=%b", got, exp_v); end
    set_id(1, 5, 0, 0, 0, 0, 0, 1, 0, 0);
    got = outs(); exp_v = pack(2, 0, 0, 0, 0); n_cmp++;
    $display("chk skip_x0 got=%b exp=%b", got, exp_v);
    if (got !== exp_v) begin n_fail++; $display("FAIL skip_x0 got=%b exp=%b", got, exp_v); end
  endtask

  task automatic test_load_use();
    drain();
    issue_load(7);
    set_id(1, 3, 7, 0, 0, 0, 1, 1, 0, 1);
    got = outs(); exp_v = pack(0, 0, 0, 1, 1); n_cmp++;
    $display("chk lu_stall got=%b exp=%b", got, exp_v);
    if (got !== exp_v) begin n_fail++; $display("FAIL lu_stall got=%b exp=%b", got, exp_v); end
    tick();
    got = outs(); exp_v = pack(0, 0, 0, 2, 0); n_cmp++;
    $display("chk lu_release got=%b exp=%b", got, exp_v);
    if (got !== exp_v) begin n_fail++; $display("FAIL lu_release got=%b exp=%b", got, exp_v); end
    drain();
    issue_load(7);
    set_id(1, 0, 7, 9, 1, 0, 0, 1, 0, 0);
    got = outs(); exp_v = pack(0, 0, 0, 0, 0); n_cmp++;
    $display("chk lu_imm got=%b exp=%b", got, exp_v);
    if (got !== exp_v) begin n_fail++; $display("FAIL lu_imm got=%b exp=%b", got, exp_v); end
    set_id(1, 7, 0, 9, 1, 0, 0, 1, 0, 0);
    got = outs(); exp_v = pack(1, 0, 0, 0, 1); n_cmp++;
    $display("chk lu_rs1 got=%b exp=%b", got, exp_v);
    if (got !== exp_v) begin n_fail++; $display("FAIL lu_rs1 got=%b exp=%b", got, exp_v); end
  endtask

  task automatic test_stall_ext();
    drain();
    issue_load(7);
    set_id(1, 2, 7, 0, 0, 0, 0, 1, 1, 0);
    got = outs(); exp_v = pack(0, 0, 0, 1, 1); n_cmp++;
    $display("chk se_stall got=%b exp=%b", got, exp_v);
    if (got !== exp_v) begin n_fail++; $display("FAIL se_stall got=%b exp=%b", got, exp_v); end
    bus.stall_ext = 1'b1;
    tick();
    tick();
    got = outs(); exp_v = pack(0, 0, 0, 1, 1); n_cmp++;
    $display("chk se_hold got=%b exp=%b", got, exp_v);
    if (got !== exp_v) begin n_fail++; $display("FAIL se_hold got=%b exp=%b", got, exp_v); end
    bus.stall_ext = 1'b0;
    tick();
    got = outs(); exp_v = pack(0, 0, 0, 2, 0); n_cmp++;
    $display("chk se_release got=%b exp=%b", got, exp_v);
    if (got !== exp_v) begin n_fail++; $display("FAIL se_release got=%b exp=%b", got, exp_v); end
  endtask

  task automatic test_flush();
    drain();
    set_id(1, 0, 0, 9, 1, 0, 0, 1, 0, 0);
    bus.flush_ex = 1'b1;
    tick();
    bus.flush_ex = 1'b0;
    set_id(1, 9, 0, 0, 0, 0, 0, 1, 0, 0);
    got = outs(); exp_v = pack(0, 0, 0, 0, 0); n_cmp++;
    $display("chk flush got=%b exp=%b", got, exp_v);
    if (got !== exp_v) begin n_fail++; $display("FAIL flush got=%b exp=%b", got, exp_v); end
  endtask

  task automatic test_rst_stall();
    drain();
    issue_load(7);
    set_id(1, 7, 0, 0, 0, 0, 0, 1, 0, 0);
    got = outs(); exp_v = pack(1, 0, 0, 0, 1); n_cmp++;
    $display("chk pre_rst got=%b exp=%b", got, exp_v);
    if (got !== exp_v) begin n_fail++; $display("FAIL pre_rst got=%b exp=%b", got, exp_v); end
    rst = 1'b1;
    #1;
    got = outs(); exp_v = pack(0, 0, 0, 0, 0); n_cmp++;
    $display("chk in_rst got=%b exp=%b", got, exp_v);
    if (got !== exp_v) begin n_fail++; $display("FAIL in_rst got=%b exp=%b", got, exp_v); end
    tick();
    rst = 1'b0;
    #1;
    got = outs(); exp_v = pack(0, 0, 0, 0, 0); n_cmp++;
    $display("chk post_rst got=%b exp=%b", got, exp_v);
    if (got !== exp_v) begin n_fail++; $display("FAIL post_rst got=%b exp=%b", got, exp_v); end
  endtask

  task automatic test_back_to_back();
    drain();
    issue_load(7);
    issue_load(7);
    set_id(1, 7, 0, 0, 0, 0, 0, 1, 0, 0);
    got = outs(); exp_v = pack(1, 0, 0, 0, 1); n_cmp++;
    $display("chk b2b_ld got=%b exp=%b", got, exp_v);
    if (got !== exp_v) begin n_fail++; $display("FAIL b2b_ld got=%b exp=%b", got, exp_v); end
    drain();
    issue_load(7);
    issue_alu(7);
    set_id(1, 7, 0, 0, 0, 0, 0, 1, 0, 0);
    got = outs(); exp_v = pack(1, 0, 0, 0, 0); n_cmp++;
    $display("chk young_alu got=%b exp=%b", got, exp_v);
    if (got !== exp_v) begin n_fail++; $display("FAIL young_alu got=%b exp=%b", got, exp_v); end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_basic();
    test_youngest();
    test_load_use();
    test_stall_ext();
    test_flush();
    test_rst_stall();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ama_riscv_fwd_hazard_unit.md
Name: ama_riscv_fwd_hazard_unit

Overview:
- Parametrised successor to the single-stage operand forwarding logic.
- Tracks destination registers of the NUM_STAGES instructions in flight after ID in an internal shift register.
- Produces per-operand forwarding selects (ALU A/B, branch compare A/B, store data) with youngest-producer priority.
- Detects load-use hazards and raises a stall with bubble insertion; sits beside the ID stage and drives the EX-input operand muxes and the ID/IF stall controls.

Parameters:
- NUM_STAGES, 3, number of tracked post-ID stages (1=EX, 2=MEM, 3=WB); legal range 1..7.
- RF_ADDR_W, 5, register index width.
- LOAD_LAT, 1, a load result is forwardable only from stage index > LOAD_LAT; must be < NUM_STAGES.
- SEL_W, $clog2(NUM_STAGES+1), derived width of every select output.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID holds a real instruction
- rs1_id  in  RF_ADDR_W  source register 1 of the ID instruction
- rs2_id  in  RF_ADDR_W  source register 2 of the ID instruction
- rd_id  in  RF_ADDR_W  destination of the ID instruction
- reg_we_id  in  1  ID instruction writes rd
- load_inst_id  in  1  ID instruction is a load
- alu_a_sel  in  1  1 = ALU A takes PC (rs1 unused by ALU)
- alu_b_sel  in  1  1 = ALU B takes immediate (rs2 unused by ALU)
- store_inst_id  in  1  ID instruction is a store
- branch_inst_id  in  1  ID instruction is a branch
- stall_ext  in  1  external pipeline freeze (e.g. DMEM wait)
- flush_ex  in  1  squash the instruction entering EX (mispredict)
- alu_a_sel_fwd  out  SEL_W  0 = no forward, k = forward from stage k
- alu_b_sel_fwd  out  SEL_W  same encoding
- bc_a_sel_fwd  out  SEL_W  branch compare A forward select
- bcs_b_sel_fwd  out  SEL_W  branch compare B / store data forward select
- stall_id  out  1  load-use hazard: hold IF/ID, insert bubble into EX

Behaviour:
- Tracker entry per stage k = 1..NUM_STAGES holds {vld, we, ld, rd}. Reset clears all vld/we/ld and zeroes rd.
- Advance rules, evaluated each posedge, first match wins:
  - rst: clear all entries.
  - stall_ext: hold all entries.
  - otherwise: entry k <- entry k-1 for k >= 2.
  - Entry 1 <- {id_valid, reg_we_id, load_inst_id, rd_id}, except it is forced to a bubble (all zero) when stall_id or flush_ex is high.
- Match(k, rs) = vld_k & we_k & (rs != 0) & (rd_k == rs).
- Youngest producer wins: the select is the smallest matching k; 0 if none.
- Use qualifiers; a select is forced to 0 when its operand is not consumed:
  - alu_a: !alu_a_sel
  - alu_b: !alu_b_sel
  - bc_a: branch_inst_id
  - bcs_b: store_inst_id | branch_inst_id
  - Every select is also forced to 0 when !id_valid.
- stall_id = id_valid & (for rs1 or rs2: the operand is consumed by any qualifier, the youngest match k <= LOAD_LAT, and ld_k = 1).
- An older non-load matching producer does not stall if a younger one matches.
- While stall_id is high, the selects still reflect the current match; the consumer ignores them that cycle.
- All outputs are combinational from tracker state and ID inputs, zero latency.
- During rst and in the cycle after reset, all outputs are 0: the tracker is empty and selects are masked by rst.
- x0 never forwards and never stalls.
- Back-to-back loads to the same rd: the youngest decides.
- rst mid-stall: the tracker clears and stall_id drops the next cycle.

Optional Feature:
- Macro: AMA_RISCV_FWD_PERF_CNT_EN.
- When defined, adds outputs fwd_cnt[31:0] and stall_cnt[31:0]:
  - fwd_cnt increments once per cycle in which any select is nonzero and neither stall_id nor stall_ext is high.
  - stall_cnt increments each cycle stall_id is high.
  - Both counters saturate at 32'hFFFF_FFFF and clear on rst.
- When undefined, the ports and logic are absent; functional behaviour is identical.

Decomposition:
- Shared defines: FWD_SEL_NONE = 0, stage index constants (FWD_STAGE_EX = 1, FWD_STAGE_MEM = 2, FWD_STAGE_WB = 3), RF_X0_ZERO.
- One sub-module, ama_riscv_fwd_prio_enc: priority encoder from a NUM_STAGES-bit match vector to SEL_W index plus a found flag. It is instantiated 4 times. Tracker and stall logic stay in the top module.

Test Plan:
- Defaults; EX add x5; ID add rs1=x5, rs2=x6 -> alu_a_sel_fwd=1, alu_b_sel_fwd=0, stall_id=0.
- x5 written in both MEM (k=2) and EX (k=1); ID rs1=x5 -> alu_a_sel_fwd=1 (youngest wins). Then rd=x0 in EX with rs1=x0 -> 0.
- Load x7 in EX; ID rs2=x7 branch -> stall_id=1 for one cycle and a bubble in EX; next cycle bcs_b_sel_fwd=2, stall_id=0.
- Load x7 in EX, but ID alu_b_sel=1 and not store/branch -> stall_id=0, alu_b_sel_fwd=0.
- Load-use with stall_ext=1 -> tracker holds, stall_id stays 1; release -> bubble, then forward from stage 2.
- flush_ex with a producer x9 in ID; next cycle ID rs1=x9 -> alu_a_sel_fwd=0. Assert rst during a stall -> all outputs 0 next cycle.
